// File: rtl/map_pkg.sv
// Shared constants and encodings for the level-map scanner and its row timer.
package map_pkg;
  localparam int MAP_ADDR_W = 6;
  localparam int MAP_ROWS   = 8;
  localparam logic [7:0] ROW_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_UP   = 2'd1,
    PEND_DN   = 2'd2
  } scroll_pend_t;

  function automatic logic [7:0] player_mask(input logic [2:0] x);
    return 8'h80 >> x;
  endfunction
endpackage

// File: rtl/map_row_timer.sv
// Row hold timer: loads ROW_HOLD-1 while fetching, counts down while showing,
// o_done is high on the last cycle a row stays lit.
module map_row_timer #(
  parameter int ROW_HOLD = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_done
);
  localparam int CW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(ROW_HOLD - 1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = i_run && (r_cnt == '0);
endmodule

// File: rtl/map_scanner.sv
// Level-map ROM reader and 8x8 LED matrix row scanner with frame-synchronous vertical scroll.
// Optional player overlay dot enabled by `define MAP_PLAYER_OVERLAY_EN.
module map_scanner
  import map_pkg::*;
#(
  parameter int ROW_HOLD = 1000,
  parameter int ADDR_W   = MAP_ADDR_W,
  parameter int ROWS     = MAP_ROWS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_scroll_up,
  input  logic              i_scroll_dn,
  output logic [ADDR_W-1:0] o_map_addr,
  input  logic [7:0]        i_map_data,
  output logic [ROWS-1:0]   o_row_sel,
  output logic [7:0]        o_col_data,
  output logic [ADDR_W-1:0] o_base_addr,
`ifdef MAP_PLAYER_OVERLAY_EN
  input  logic [2:0]        i_player_x,
  input  logic [2:0]        i_player_y,
`endif
  output logic              o_frame_done
);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROWS-1:0] BLANK = ROWS'(ROW_BLANK);

  scan_state_t       r_state;
  scroll_pend_t      r_pend;
  logic [RIW-1:0]    r_row_idx;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_map_addr;
  logic [ROWS-1:0]   r_row_sel;
  logic [7:0]        r_col_data;
  logic              r_frame_done;

  logic              w_hold_done;
  logic              w_last_row;
  logic              w_apply;
  logic [RIW-1:0]    w_row_inc;
  logic [ADDR_W-1:0] w_base_nxt;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ROWS-1:0]   w_row_on;
  logic [7:0]        w_col_nxt;
  scroll_pend_t      w_pend_nxt;

  map_row_timer #(.ROW_HOLD(ROW_HOLD)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (r_state == ST_FETCH),
    .i_run   (r_state == ST_SHOW),
    .o_done  (w_hold_done)
  );

  assign w_last_row  = (r_row_idx == RIW'(ROWS - 1));
  assign w_apply     = i_en && (r_state == ST_SHOW) && w_hold_done && w_last_row;
  assign w_row_inc   = r_row_idx + RIW'(1);
  assign w_next_addr = r_base + ADDR_W'(w_row_inc);
  assign w_row_on    = ~(ROWS'(1) << r_row_idx);

  always_comb begin
    w_base_nxt = r_base;
    case (r_pend)
      PEND_UP: w_base_nxt = r_base + ADDR_W'(1);
      PEND_DN: w_base_nxt = r_base - ADDR_W'(1);
      default: w_base_nxt = r_base;
    endcase
  end

  // A request landing on the apply edge survives into the next frame.
  always_comb begin
    w_pend_nxt = w_apply ? PEND_NONE : r_pend;
    if (i_scroll_up && !i_scroll_dn) begin
      w_pend_nxt = PEND_UP;
    end else if (i_scroll_dn && !i_scroll_up) begin
      w_pend_nxt = PEND_DN;
    end
  end

  always_comb begin
    w_col_nxt = i_map_data;
`ifdef MAP_PLAYER_OVERLAY_EN
    if (3'(r_row_idx) == i_player_y) begin
      w_col_nxt = i_map_data | player_mask(i_player_x);
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_pend       <= PEND_NONE;
      r_row_idx    <= '0;
      r_base       <= '0;
      r_map_addr   <= '0;
      r_row_sel    <= BLANK;
      r_col_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_pend       <= w_pend_nxt;
      if (!i_en) begin
        r_state    <= ST_IDLE;
        r_row_idx  <= '0;
        r_map_addr <= r_base;
        r_row_sel  <= BLANK;
        r_col_data <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_FETCH;
            r_row_idx  <= '0;
            r_map_addr <= r_base;
          end
          ST_FETCH: begin
            r_state    <= ST_SHOW;
            r_row_sel  <= w_row_on;
            r_col_data <= w_col_nxt;
          end
          ST_SHOW: begin
            if (w_hold_done) begin
              // Row lines blank for the fetch cycle so the next row never ghosts.
              r_state    <= ST_FETCH;
              r_row_sel  <= BLANK;
              r_col_data <= '0;
              if (w_last_row) begin
                r_row_idx    <= '0;
                r_base       <= w_base_nxt;
                r_map_addr   <= w_base_nxt;
                r_frame_done <= 1'b1;
              end else begin
                r_row_idx  <= w_row_inc;
                r_map_addr <= w_next_addr;
              end
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_row_sel <= BLANK;
          end
        endcase
      end
    end
  end

  assign o_map_addr   = r_map_addr;
  assign o_row_sel    = r_row_sel;
  assign o_col_data   = r_col_data;
  assign o_base_addr  = r_base;
  assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_map_scanner.sv
// Bench for map_scanner: directed frame/scroll/enable checks plus randomized run against a frame-position model.
module tb_map_scanner;
  localparam int H     = 2;
  localparam int RP    = H + 1;
  localparam int FRAME = 8 * RP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       scroll_up = 1'b0;
  logic       scroll_dn = 1'b0;
  logic [5:0] map_addr;
  logic [7:0] map_data;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic [5:0] base_addr;
  logic       frame_done;
  logic [2:0] player_x = 3'd0;
  logic [2:0] player_y = 3'd3;

  logic [7:0] rom [64];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  assign map_data = rom[map_addr];

  map_scanner #(.ROW_HOLD(H)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_scroll_up  (scroll_up),
    .i_scroll_dn  (scroll_dn),
    .o_map_addr   (map_addr),
    .i_map_data   (map_data),
    .o_row_sel    (row_sel),
    .o_col_data   (col_data),
    .o_base_addr  (base_addr),
`ifdef MAP_PLAYER_OVERLAY_EN
    .i_player_x   (player_x),
    .i_player_y   (player_y),
`endif
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ovl(input int row);
`ifdef MAP_PLAYER_OVERLAY_EN
    if (row == int'(player_y)) return 8'h80 >> player_x;
`endif
    return 8'h00;
  endfunction

  // Model: position within the frame since scanning started, plus base and pending scroll.
  bit         m_run = 0;
  int         m_t = 0;
  int         m_base = 0;
  int         m_pend = 0;
  bit         m_fd = 0;
  logic [7:0] m_col = 8'h00;
  bit         m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_base = 0; m_pend = 0; m_fd = 0; m_col = 8'h00;
    end else begin
      m_wrap = 0;
      m_fd   = 0;
      if (!en) begin
        m_run = 0;
      end else if (!m_run) begin
        m_run = 1;
        m_t   = 0;
      end else begin
        m_t++;
        if (m_t == FRAME) begin
          m_t    = 0;
          m_wrap = 1;
          m_fd   = 1;
          m_base = (m_base + m_pend) & 63;
        end
        if (m_t % RP == 1)
          m_col = rom[(m_base + m_t / RP) & 63] | ovl(m_t / RP);
      end
      if (m_wrap) m_pend = 0;
      if (scroll_up != scroll_dn) m_pend = scroll_up ? 1 : -1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int row;
      logic [5:0] e_addr;
      logic [7:0] e_sel, e_col;
      row = m_t / RP;
      if (!m_run) begin
        e_addr = 6'(m_base); e_sel = 8'hFF; e_col = 8'h00;
      end else if (m_t % RP == 0) begin
        e_addr = 6'((m_base + row) & 63); e_sel = 8'hFF; e_col = 8'h00;
      end else begin
        e_addr = 6'((m_base + row) & 63); e_sel = ~(8'h01 << row); e_col = m_col;
      end
      chk("m_map_addr", 32'(map_addr), 32'(e_addr));
      chk("m_row_sel", 32'(row_sel), 32'(e_sel));
      chk("m_col_data", 32'(col_data), 32'(e_col));
      chk("m_base_addr", 32'(base_addr), 32'(m_base[5:0]));
      chk("m_frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h3C; rom[1] = 8'h42; rom[2] = 8'hA5; rom[3] = 8'h99; rom[8] = 8'h01;

    repeat (3) @(negedge clk);
    chk("rst_row_sel", 32'(row_sel), 32'hFF);
    chk("rst_col_data", 32'(col_data), 32'h00);
    chk("rst_map_addr", 32'(map_addr), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk_on = 1;
    en = 1'b1;

    // k counts cycles from the first FETCH of the first frame.
    for (int k = 0; k < 146; k++) begin
      @(negedge clk);
      if (k < 24 && k % 3 == 0) chk("d_fetch_addr", 32'(map_addr), 32'(k / 3));
      if (k == 0)  chk("d_fetch_blank", 32'(row_sel), 32'hFF);
      if (k == 1)  begin chk("d_r0_sel", 32'(row_sel), 32'hFE); chk("d_r0_col", 32'(col_data), 32'h3C); end
      if (k == 7)  begin chk("d_r2_sel", 32'(row_sel), 32'hFB); chk("d_r2_col", 32'(col_data), 32'hA5); end
      if (k == 23) chk("d_fd_early", 32'(frame_done), 32'h0);
      if (k == 24) begin chk("d_fd_24", 32'(frame_done), 32'h1); chk("d_f2_addr", 32'(map_addr), 32'h0); end
`ifdef MAP_PLAYER_OVERLAY_EN
      if (k == 34) chk("d_ovl_r3", 32'(col_data), 32'h99);
`endif
      if (k == 45) begin chk("d_noscroll_addr", 32'(map_addr), 32'h07); chk("d_noscroll_base", 32'(base_addr), 32'h0); end
      if (k == 48) begin chk("d_up_addr", 32'(map_addr), 32'h01); chk("d_up_base", 32'(base_addr), 32'h01); end
      if (k == 69) chk("d_up_r7_addr", 32'(map_addr), 32'h08);
      if (k == 70) begin chk("d_up_r7_col", 32'(col_data), 32'h01); chk("d_up_r7_sel", 32'(row_sel), 32'h7F); end
      if (k == 72) chk("d_dn_base0", 32'(base_addr), 32'h00);
      if (k == 96) begin chk("d_dn_base63", 32'(base_addr), 32'h3F); chk("d_wrap_a63", 32'(map_addr), 32'h3F); end
      if (k == 99)  chk("d_wrap_a0", 32'(map_addr), 32'h00);
      if (k == 102) chk("d_wrap_a1", 32'(map_addr), 32'h01);
      if (k == 120) chk("d_both_base", 32'(base_addr), 32'h3F);
      if (k == 137) begin chk("d_off_sel", 32'(row_sel), 32'hFF); chk("d_off_col", 32'(col_data), 32'h00); end
      if (k == 140) begin chk("d_restart_addr", 32'(map_addr), 32'h3F); chk("d_restart_sel", 32'(row_sel), 32'hFF); end
      if (k == 141) begin chk("d_restart_r0", 32'(row_sel), 32'hFE); chk("d_restart_col", 32'(col_data), 32'(rom[63])); end
      scroll_up = (k == 33) || (k == 100);
      scroll_dn = (k == 50) || (k == 75) || (k == 100);
      en = !(k >= 135 && k < 139);
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(99) == 0) en = ~en;
      scroll_up = ($urandom_range(29) == 0);
      scroll_dn = ($urandom_range(29) == 0);
      if ($urandom_range(199) == 0) begin
        player_x = 3'($urandom);
        player_y = 3'($urandom);
      end
    end

    scroll_up = 1'b0; scroll_dn = 1'b0; en = 1'b1;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (row_sel != 8'hFF) found = 1;
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL show_wait: no lit row within 60 cycles");
    end else begin
      #2 rst_n = 1'b0;
      #1;
      chk("ar_row_sel", 32'(row_sel), 32'hFF);
      chk("ar_col_data", 32'(col_data), 32'h00);
      chk("ar_map_addr", 32'(map_addr), 32'h00);
      chk("ar_base_addr", 32'(base_addr), 32'h00);
      chk("ar_frame_done", 32'(frame_done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (30) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
